r5p_bus_arb: RTL and testbench

R5P_BUS_ARB -- requirements
Module: r5p_bus_arb

---
 rtl/r5p_bus_arb.sv | 141 ++++++++++++++
 tb/tb_r5p_bus_arb.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/r5p_bus_arb.sv
// Round-robin arbiter that lets MN masters share one slave port with 1-cycle read latency.
// A stalled request is latched and pinned to its master until the slave accepts it.

module r5p_bus_arb_lane #(
    parameter int IDX = 0,
    parameter int IW  = 1
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          act,
    input  logic [IW-1:0] gnt_idx,
    input  logic          s_rdy,
    input  logic          wen,
    output logic          rdy,
    output logic          rvl
);
    logic sel;

    assign sel = act & (gnt_idx == IW'(IDX));
    assign rdy = sel & s_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rvl <= 1'b0;
        else      rvl <= rdy & ~wen;
    end
endmodule

module r5p_bus_arb #(
    parameter int AW = 15,
    parameter int DW = 32,
    parameter int BW = DW/8,
    parameter int MN = 2
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MN-1:0]         m_vld,
    input  logic [MN-1:0]         m_wen,
    input  logic [MN-1:0][AW-1:0] m_adr,
    input  logic [MN-1:0][BW-1:0] m_ben,
    input  logic [MN-1:0][DW-1:0] m_wdt,
    output logic [MN-1:0]         m_rdy,
    output logic [DW-1:0]         m_rdt,
    output logic [MN-1:0]         m_rvl,
    output logic                  s_vld,
    output logic                  s_wen,
    output logic [AW-1:0]         s_adr,
    output logic [BW-1:0]         s_ben,
    output logic [DW-1:0]         s_wdt,
    input  logic [DW-1:0]         s_rdt,
    input  logic                  s_rdy
);
    localparam int IW = (MN > 1) ? $clog2(MN) : 1;

    typedef struct packed {
        logic          wen;
        logic [AW-1:0] adr;
        logic [BW-1:0] ben;
        logic [DW-1:0] wdt;
    } req_t;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] ptr, own, arb_idx, gnt_idx;
    logic [IW:0]   cand;
    logic          arb_hit, act, xfer;
    req_t          hold_req, cur_req;

    // Scan MN candidates starting just after ptr, wrapping modulo MN.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        cand    = '0;
        for (int k = 1; k <= MN; k++) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(MN)) cand = cand - (IW+1)'(MN);
            if (!arb_hit && m_vld[cand[IW-1:0]]) begin
                arb_hit = 1'b1;
                arb_idx = cand[IW-1:0];
            end
        end
    end

    assign gnt_idx = (state == HOLD) ? own : arb_idx;
    assign act     = rst & ((state == HOLD) | arb_hit);
    assign xfer    = act & s_rdy;

    // While held, the latched copy is replayed so a withdrawn request still completes.
    always_comb begin
        cur_req.wen = m_wen[gnt_idx];
        cur_req.adr = m_adr[gnt_idx];
        cur_req.ben = m_ben[gnt_idx];
        cur_req.wdt = m_wdt[gnt_idx];
        if (state == HOLD) cur_req = hold_req;
    end

    assign s_vld = act;
    assign s_wen = act & cur_req.wen;
    assign s_adr = act ? cur_req.adr : '0;
    assign s_ben = act ? cur_req.ben : '0;
    assign s_wdt = act ? cur_req.wdt : '0;
    assign m_rdt = s_rdt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (act && !s_rdy) state_nxt = HOLD;
            HOLD:    if (s_rdy)         state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= IW'(MN-1);
            own      <= '0;
            hold_req <= '0;
        end else begin
            state <= state_nxt;
            if (xfer) ptr <= gnt_idx;
            if (state == IDLE && act && !s_rdy) begin
                own      <= arb_idx;
                hold_req <= cur_req;
            end
        end
    end

    for (genvar i = 0; i < MN; i++) begin : g_lane
        r5p_bus_arb_lane #(.IDX(i), .IW(IW)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .act     (act),
            .gnt_idx (gnt_idx),
            .s_rdy   (s_rdy),
            .wen     (cur_req.wen),
            .rdy     (m_rdy[i]),
            .rvl     (m_rvl[i])
        );
    end
endmodule

// File: tb/tb_r5p_bus_arb.sv
// Bench for r5p_bus_arb: directed scenarios on a 2-master instance, then a 3-master
// instance with round-robin fairness and randomized traffic against a behavioural model.

module tb_r5p_bus_arb;
    localparam int AW = 15;
    localparam int DW = 32;
    localparam int BW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    endtask

    // 2-master instance
    logic [1:0]         a_vld, a_wen, a_rdy, a_rvl;
    logic [1:0][AW-1:0] a_adr;
    logic [1:0][BW-1:0] a_ben;
    logic [1:0][DW-1:0] a_wdt;
    logic [DW-1:0]      a_rdt, a_swdt, a_srdt;
    logic               a_svld, a_swen, a_srdy;
    logic [AW-1:0]      a_sadr;
    logic [BW-1:0]      a_sben;

    // 3-master instance
    logic [2:0]         b_vld, b_wen, b_rdy, b_rvl;
    logic [2:0][AW-1:0] b_adr;
    logic [2:0][BW-1:0] b_ben;
    logic [2:0][DW-1:0] b_wdt;
    logic [DW-1:0]      b_rdt, b_swdt, b_srdt;
    logic               b_svld, b_swen, b_srdy;
    logic [AW-1:0]      b_sadr;
    logic [BW-1:0]      b_sben;

    r5p_bus_arb #(.AW(AW), .DW(DW), .BW(BW), .MN(2)) u_a (
        .clk(clk), .rst(rst),
        .m_vld(a_vld), .m_wen(a_wen), .m_adr(a_adr), .m_ben(a_ben), .m_wdt(a_wdt),
        .m_rdy(a_rdy), .m_rdt(a_rdt), .m_rvl(a_rvl),
        .s_vld(a_svld), .s_wen(a_swen), .s_adr(a_sadr), .s_ben(a_sben), .s_wdt(a_swdt),
        .s_rdt(a_srdt), .s_rdy(a_srdy)
    );

    r5p_bus_arb #(.AW(AW), .DW(DW), .BW(BW), .MN(3)) u_b (
        .clk(clk), .rst(rst),
        .m_vld(b_vld), .m_wen(b_wen), .m_adr(b_adr), .m_ben(b_ben), .m_wdt(b_wdt),
        .m_rdy(b_rdy), .m_rdt(b_rdt), .m_rvl(b_rvl),
        .s_vld(b_svld), .s_wen(b_swen), .s_adr(b_sadr), .s_ben(b_sben), .s_wdt(b_swdt),
        .s_rdt(b_srdt), .s_rdy(b_srdy)
    );

    // reference model state for the 3-master instance
    bit            pend[3];
    bit            p_wen[3];
    logic [AW-1:0] p_adr[3];
    logic [BW-1:0] p_ben[3];
    logic [DW-1:0] p_wdt[3];
    int            m_ptr, m_own, m_rvl, cnt[3];
    bit            m_hold, h_wen;
    logic [AW-1:0] h_adr;
    logic [BW-1:0] h_ben;
    logic [DW-1:0] h_wdt;

    initial begin
        a_vld = '0; a_wen = '0; a_adr = '0; a_ben = '0; a_wdt = '0; a_srdt = '0; a_srdy = 1'b0;
        b_vld = '0; b_wen = '0; b_adr = '0; b_ben = '0; b_wdt = '0; b_srdt = '0; b_srdy = 1'b0;

        // requests pending during reset must not leak out
        a_vld = 2'b11; b_vld = 3'b111; a_srdy = 1'b1; b_srdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_svld", a_svld, 1'b0);
        chk("rst_rdy", a_rdy, 2'b00);
        chk("rst_rvl", a_rvl, 2'b00);
        chk("rst_b_svld", b_svld, 1'b0);
        chk("rst_b_rdy", b_rdy, 3'b000);
        b_vld = '0;

        // both masters read continuously: 0,1,0,1 with m_rvl one cycle behind
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) begin
                rst = 1'b1; a_vld = 2'b11; a_wen = 2'b00;
                a_adr[0] = 15'h100; a_adr[1] = 15'h200;
            end
            #1;
            chk("alt_rdy", a_rdy, (c % 2 == 0) ? 2'b01 : 2'b10);
            chk("alt_adr", a_sadr, (c % 2 == 0) ? 15'h100 : 15'h200);
            chk("alt_rvl", a_rvl, (c == 0) ? 2'b00 : ((c % 2 == 0) ? 2'b10 : 2'b01));
        end

        @(negedge clk); a_vld = 2'b00; #1;
        chk("idle_svld", a_svld, 1'b0);
        chk("idle_rvl", a_rvl, 2'b10);

        // master 1 alone writes
        @(negedge clk);
        a_vld = 2'b10; a_wen = 2'b10; a_adr[1] = 15'h10; a_ben[1] = 4'hF; a_wdt[1] = 32'h12345678;
        #1;
        chk("wr_rdy", a_rdy, 2'b10);
        chk("wr_adr", a_sadr, 15'h10);
        chk("wr_wen", a_swen, 1'b1);
        chk("wr_ben", a_sben, 4'hF);
        chk("wr_wdt", a_swdt, 32'h12345678);
        chk("wr_rvl0", a_rvl, 2'b00);
        @(negedge clk); a_vld = 2'b00; a_wen = 2'b00; #1;
        chk("wr_rvl1", a_rvl, 2'b00);

        // master 0 read stalled 3 cycles while master 1 waits
        a_adr[0] = 15'h123; a_adr[1] = 15'h55;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            a_vld = (c <= 4) ? 2'b11 : 2'b10;
            a_srdy = (c >= 4);
            #1;
            chk("stall_adr", a_sadr, (c <= 4) ? 15'h123 : 15'h55);
            chk("stall_rdy", a_rdy, (c <= 3) ? 2'b00 : ((c == 4) ? 2'b01 : 2'b10));
            chk("stall_svld", a_svld, 1'b1);
            if (c == 5) chk("stall_rvl", a_rvl, 2'b01);
        end

        // master 1 held, then withdraws and changes address while master 0 requests
        @(negedge clk); a_vld = 2'b10; a_srdy = 1'b0; #1;
        chk("wd_adrA", a_sadr, 15'h55);
        chk("wd_rvlA", a_rvl, 2'b10);
        chk("wd_rdyA", a_rdy, 2'b00);
        @(negedge clk); a_vld = 2'b01; a_adr[1] = 15'h77; #1;
        chk("wd_svld", a_svld, 1'b1);
        chk("wd_adrB", a_sadr, 15'h55);
        chk("wd_rdyB", a_rdy, 2'b00);
        @(negedge clk); a_srdy = 1'b1; #1;
        chk("wd_rdyC", a_rdy, 2'b10);
        chk("wd_adrC", a_sadr, 15'h55);

        // read by 0 then write by 1 back to back
        @(negedge clk); a_vld = 2'b01; a_wen = 2'b00; #1;
        chk("rw_rdyD", a_rdy, 2'b01);
        chk("rw_rvlD", a_rvl, 2'b10);
        @(negedge clk); a_vld = 2'b10; a_wen = 2'b10; a_srdt = 32'hCAFEF00D; #1;
        chk("rw_rvlE", a_rvl, 2'b01);
        chk("rw_rdyE", a_rdy, 2'b10);
        chk("rw_rdt", a_rdt, 32'hCAFEF00D);

        // reset while holding master 1
        @(negedge clk); a_vld = 2'b10; a_wen = 2'b00; a_srdy = 1'b0; #1;
        chk("hr_rdyF", a_rdy, 2'b00);
        @(negedge clk); a_vld = 2'b11; #1;
        chk("hr_svld", a_svld, 1'b1);
        chk("hr_adr", a_sadr, 15'h77);
        #2; a_srdy = 1'b1; rst = 1'b0; #1;
        chk("hr_rst_svld", a_svld, 1'b0);
        chk("hr_rst_rdy", a_rdy, 2'b00);
        chk("hr_rst_rvl", a_rvl, 2'b00);
        @(posedge clk); @(negedge clk); rst = 1'b1; #1;
        chk("rel_rdy", a_rdy, 2'b01);
        chk("rel_rvl", a_rvl, 2'b00);

        // reset right after a read transfer drops the pending response
        @(posedge clk); #1; rst = 1'b0; #1;
        chk("drop_rvl", a_rvl, 2'b00);
        @(negedge clk); rst = 1'b1; a_vld = 2'b00; #1;
        chk("drop_rvl_rel", a_rvl, 2'b00);
        @(negedge clk); #1;
        chk("drop_rvl_next", a_rvl, 2'b00);

        // 3 masters, all requesting reads for 9 cycles
        cnt = '{0, 0, 0};
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c == 0) begin
                b_vld = 3'b111; b_wen = 3'b000; b_srdy = 1'b1;
                for (int i = 0; i < 3; i++) b_adr[i] = AW'(16'h300 + i);
            end
            #1;
            chk("rr3_rdy", b_rdy, 3'b001 << (c % 3));
            for (int i = 0; i < 3; i++) if (b_rdy[i]) cnt[i]++;
        end
        for (int i = 0; i < 3; i++) chk("rr3_cnt", cnt[i], 3);

        // randomized traffic vs model; masters hold requests until accepted
        m_ptr = 2; m_hold = 1'b0; m_own = 0; m_rvl = 4;
        h_wen = 1'b0; h_adr = '0; h_ben = '0; h_wdt = '0;
        for (int i = 0; i < 3; i++) pend[i] = 1'b0;
        for (int t = 0; t < 400; t++) begin
            int  win;
            bit  xfer, w_wen;
            logic [AW-1:0] w_adr;
            logic [BW-1:0] w_ben;
            logic [DW-1:0] w_wdt;
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i]  = 1'b1;
                    p_wen[i] = 1'($urandom_range(0, 1));
                    p_adr[i] = AW'($urandom);
                    p_ben[i] = BW'($urandom);
                    p_wdt[i] = $urandom;
                end
                b_vld[i] = pend[i];
                b_wen[i] = p_wen[i];
                b_adr[i] = p_adr[i];
                b_ben[i] = p_ben[i];
                b_wdt[i] = p_wdt[i];
            end
            b_srdy = ($urandom_range(0, 3) != 0);
            b_srdt = $urandom;

            win = -1;
            if (m_hold) win = m_own;
            else for (int k = 1; k <= 3; k++)
                if (win < 0 && pend[(m_ptr + k) % 3]) win = (m_ptr + k) % 3;
            xfer = (win >= 0) && b_srdy;
            w_wen = 1'b0; w_adr = '0; w_ben = '0; w_wdt = '0;
            if (m_hold) begin
                w_wen = h_wen; w_adr = h_adr; w_ben = h_ben; w_wdt = h_wdt;
            end else if (win >= 0) begin
                w_wen = p_wen[win]; w_adr = p_adr[win]; w_ben = p_ben[win]; w_wdt = p_wdt[win];
            end

            #1;
            chk("rnd_svld", b_svld, win >= 0);
            chk("rnd_rdy", b_rdy, xfer ? (3'b001 << win) : 3'b000);
            chk("rnd_rvl", b_rvl, m_rvl);
            chk("rnd_rdt", b_rdt, b_srdt);
            if (win >= 0) begin
                chk("rnd_wen", b_swen, w_wen);
                chk("rnd_adr", b_sadr, w_adr);
                chk("rnd_ben", b_sben, w_ben);
                chk("rnd_wdt", b_swdt, w_wdt);
            end

            m_rvl = (xfer && !w_wen) ? (1 << win) : 0;
            if (xfer) begin
                m_ptr = win; m_hold = 1'b0; pend[win] = 1'b0;
            end else if (win >= 0 && !m_hold) begin
                m_hold = 1'b1; m_own = win;
                h_wen = w_wen; h_adr = w_adr; h_ben = w_ben; h_wdt = w_wdt;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
